multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The module SHALL have ports `clk`, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-002 The module SHALL have port `rst`, input, 1 bit, an asynchronous active-high reset.
REQ-003 The module SHALL have port `opcode`, input, 6 bits, instruction opcode taken from the IR.
REQ-004 The module SHALL have port `mem_ready`, input, 1 bit; high means the memory access completes this cycle.
REQ-005 The module SHALL have ports `pc_write`, `pc_write_cond`, `iord`, `mem_read`, `mem_write`, `ir_write`, `reg_dest`, `mem_to_reg`, `reg_write` and `alu_src_a`, each output, 1 bit.
REQ-006 The module SHALL have port `alu_op`, output, 2 bits: 00 add, 01 sub, 10 decode by func.
REQ-007 The module SHALL have port `alu_src_b`, output, 2 bits: 00 rdat2, 01 const 4, 10 se_imm, 11 se_imm<<2.
REQ-008 The module SHALL have port `pc_source`, output, 2 bits: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 The module SHALL have port `state`, output, 4 bits, the current state encoding, for debug.
REQ-010 The module SHALL have port `illegal_op`, output, 1 bit, high while in TRAP.

Function
REQ-011 The FSM SHALL have states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11, TRAP=15.
REQ-012 The outputs SHALL be Moore outputs, a function of `state` only; every output not listed for a state SHALL be 0.
REQ-013 FETCH SHALL drive: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-014 FETCH SHALL additionally drive ir_write=1 and pc_write=1 only in the cycle where mem_ready=1.
REQ-015 FETCH SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-016 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
REQ-017 DECODE SHALL branch on `opcode`: 0x00 to EXEC_R, 0x23 or 0x2B to MEM_ADDR, 0x04 to BRANCH, 0x02 to JUMP, 0x08 to EXEC_I, any other value to TRAP.
REQ-018 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_RD if opcode=0x23, else to MEM_WR.
REQ-019 MEM_RD SHALL drive mem_read=1, iord=1, hold until mem_ready=1, then go to MEM_WB.
REQ-020 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dest=0, then go to FETCH.
REQ-021 MEM_WR SHALL drive mem_write=1, iord=1, hold until mem_ready=1, then go to FETCH.
REQ-022 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to R_WB.
REQ-023 R_WB SHALL drive reg_write=1, reg_dest=1, mem_to_reg=0, then go to FETCH.
REQ-024 EXEC_I SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to I_WB.
REQ-025 I_WB SHALL drive reg_write=1, reg_dest=0, mem_to_reg=0, then go to FETCH.
REQ-026 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-027 JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH.
REQ-028 TRAP SHALL be absorbing, driving illegal_op=1; it SHALL be exited only by reset.
REQ-029 The latencies in cycles with zero wait states SHALL be: lw 5; sw, R-type and addi 4; beq and j 3.
REQ-030 Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR SHALL add exactly one cycle; mem_ready SHALL be ignored in every other state.
REQ-031 During a wait cycle in MEM_WR, mem_write SHALL remain asserted, so the data memory commits on the mem_ready=1 cycle only.
REQ-032 `opcode` SHALL be sampled only in DECODE and MEM_ADDR, so IR changes in other states have no effect.

Reset
REQ-033 Asserting `rst` SHALL force state FETCH immediately, asynchronously, including mid-wait in MEM_RD or MEM_WR.
REQ-034 While `rst` is high, all outputs SHALL be 0 except the FETCH static values (mem_read=1, alu_src_b=01); ir_write and pc_write SHALL stay 0.
REQ-035 On the first rising edge after `rst` deasserts, the FSM SHALL evaluate FETCH normally.

Structure
REQ-036 The state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), alu_op codes and mux-select codes SHALL live in the shared package mips_pkg.
REQ-037 The block SHALL consist of one state register plus a combinational next-state/output decoder, with no sub-module.

Verification
REQ-038 The bench SHALL check: opcode=0x23, mem_ready tied 1 -> states 0,1,2,3,4,0; reg_write=1 exactly in cycle 5 with mem_to_reg=1.
REQ-039 The bench SHALL check: opcode=0x2B, mem_ready low for 2 cycles in MEM_WR -> mem_write high 3 consecutive cycles, then FETCH.
REQ-040 The bench SHALL check: opcode=0x04 -> pc_write_cond=1, alu_op=01, pc_source=01 in cycle 3, and pc_write=0 throughout.
REQ-041 The bench SHALL check: opcode=0x3F -> TRAP and illegal_op=1 held for 20 cycles; rst pulse -> FETCH, illegal_op=0.
REQ-042 The bench SHALL check: rst asserted mid-MEM_RD while mem_ready=0 -> state=0 before the next edge; no reg_write pulse follows.
REQ-043 The bench SHALL check: mem_ready=0 for 3 cycles in FETCH -> ir_write and pc_write each pulse exactly once, on the mem_ready=1 cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path.
package mips_pkg;

   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned STATE_W  = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEM_ADDR = 4'd2,
      ST_MEM_RD   = 4'd3,
      ST_MEM_WB   = 4'd4,
      ST_MEM_WR   = 4'd5,
      ST_EXEC_R   = 4'd6,
      ST_R_WB     = 4'd7,
      ST_BRANCH   = 4'd8,
      ST_JUMP     = 4'd9,
      ST_EXEC_I   = 4'd10,
      ST_I_WB     = 4'd11,
      ST_TRAP     = 4'd15
   } state_e;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_FUNC = 2'b10;

   localparam logic [1:0] SRCB_RDAT2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Full control word produced by the decoder each cycle
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dest;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_op;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS controller: state register plus combinational decoder.
module multicycle_ctrl
   import mips_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dest,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_op,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          pc_source,
   output logic [STATE_W-1:0]  state,
   output logic                illegal_op
);

   state_e r_state;
   state_e w_state_next;
   ctrl_t  w_ctrl;

   // State register; reset drops straight to FETCH even mid-wait
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_FETCH;
      else     r_state <= w_state_next;
   end

   // Next-state logic; opcode is only looked at in DECODE and MEM_ADDR
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_FETCH:    if (mem_ready) w_state_next = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_RTYPE:     w_state_next = ST_EXEC_R;
               OP_LW, OP_SW: w_state_next = ST_MEM_ADDR;
               OP_BEQ:       w_state_next = ST_BRANCH;
               OP_J:         w_state_next = ST_JUMP;
               OP_ADDI:      w_state_next = ST_EXEC_I;
               default:      w_state_next = ST_TRAP;
            endcase
         end
         ST_MEM_ADDR: w_state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:   if (mem_ready) w_state_next = ST_MEM_WB;
         ST_MEM_WB:   w_state_next = ST_FETCH;
         ST_MEM_WR:   if (mem_ready) w_state_next = ST_FETCH;
         ST_EXEC_R:   w_state_next = ST_R_WB;
         ST_R_WB:     w_state_next = ST_FETCH;
         ST_BRANCH:   w_state_next = ST_FETCH;
         ST_JUMP:     w_state_next = ST_FETCH;
         ST_EXEC_I:   w_state_next = ST_I_WB;
         ST_I_WB:     w_state_next = ST_FETCH;
         ST_TRAP:     w_state_next = ST_TRAP;
         default:     w_state_next = ST_TRAP;
      endcase
   end

   // Output decode from state; IR/PC update in FETCH only on the completing cycle
   always_comb begin
      w_ctrl = '0;
      case (r_state)
         ST_FETCH: begin
            w_ctrl.mem_read  = 1'b1;
            w_ctrl.alu_src_b = SRCB_FOUR;
            w_ctrl.alu_op    = ALU_ADD;
            w_ctrl.pc_source = PCSRC_ALU;
            w_ctrl.ir_write  = mem_ready & ~rst;
            w_ctrl.pc_write  = mem_ready & ~rst;
         end
         ST_DECODE: begin
            w_ctrl.alu_src_b = SRCB_IMM_SH;
            w_ctrl.alu_op    = ALU_ADD;
         end
         ST_MEM_ADDR, ST_EXEC_I: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = SRCB_IMM;
            w_ctrl.alu_op    = ALU_ADD;
         end
         ST_MEM_RD: begin
            w_ctrl.mem_read = 1'b1;
            w_ctrl.iord     = 1'b1;
         end
         ST_MEM_WB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.mem_to_reg = 1'b1;
         end
         ST_MEM_WR: begin
            w_ctrl.mem_write = 1'b1;
            w_ctrl.iord      = 1'b1;
         end
         ST_EXEC_R: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = SRCB_RDAT2;
            w_ctrl.alu_op    = ALU_FUNC;
         end
         ST_R_WB: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.reg_dest  = 1'b1;
         end
         ST_I_WB: begin
            w_ctrl.reg_write = 1'b1;
         end
         ST_BRANCH: begin
            w_ctrl.alu_src_a     = 1'b1;
            w_ctrl.alu_src_b     = SRCB_RDAT2;
            w_ctrl.alu_op        = ALU_SUB;
            w_ctrl.pc_write_cond = 1'b1;
            w_ctrl.pc_source     = PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            w_ctrl.pc_write  = 1'b1;
            w_ctrl.pc_source = PCSRC_JUMP;
         end
         ST_TRAP: begin
            w_ctrl.illegal_op = 1'b1;
         end
         default: w_ctrl = '0;
      endcase
   end

   assign pc_write      = w_ctrl.pc_write;
   assign pc_write_cond = w_ctrl.pc_write_cond;
   assign iord          = w_ctrl.iord;
   assign mem_read      = w_ctrl.mem_read;
   assign mem_write     = w_ctrl.mem_write;
   assign ir_write      = w_ctrl.ir_write;
   assign reg_dest      = w_ctrl.reg_dest;
   assign mem_to_reg    = w_ctrl.mem_to_reg;
   assign reg_write     = w_ctrl.reg_write;
   assign alu_src_a     = w_ctrl.alu_src_a;
   assign alu_op        = w_ctrl.alu_op;
   assign alu_src_b     = w_ctrl.alu_src_b;
   assign pc_source     = w_ctrl.pc_source;
   assign illegal_op    = w_ctrl.illegal_op;
   assign state         = r_state;

endmodule
